// File: rtl/time_disp_pkg.sv
// Shared constants for the six-digit hh.mm.ss multiplexed display:
// active-low segment codes {g,f,e,d,c,b,a}, digit positions and field limits.
package time_disp_pkg;

   localparam int unsigned NUM_DIGITS = 6;
   localparam logic [5:0]  HOURS_MAX  = 6'd23;
   localparam logic [5:0]  MINSEC_MAX = 6'd59;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Digit position, rightmost first; the value is also the an bit index.
   typedef enum logic [2:0] {
      DIG_SEC_U = 3'd0,
      DIG_SEC_T = 3'd1,
      DIG_MIN_U = 3'd2,
      DIG_MIN_T = 3'd3,
      DIG_HRS_U = 3'd4,
      DIG_HRS_T = 3'd5
   } digit_e;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd6.sv
// Combinational split of a 6-bit binary field into tens/units digits,
// flagging values above the supplied limit.
module bin2bcd6 (
   input  logic [5:0] value,
   input  logic [5:0] limit,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic       invalid
);

   assign tens    = 4'(value / 6'd10);
   assign units   = 4'(value - ({2'b00, tens} * 6'd10));
   assign invalid = (value > limit);

endmodule

// File: rtl/time_display_scan.sv
// Multiplexed six-digit time display driver. Digits come from a snapshot that
// refreshes once per full scan. Optional macro: LEADING_ZERO_BLANK_EN.
module time_display_scan
   import time_disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] hours,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   digit_e        idx_q, idx_d;
   logic          first_q;
   logic [5:0]    hrs_q, min_q, sec_q;
   logic [5:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          frame_q, frame_d;

   logic          step, take;
   logic [3:0]    hrsTens, hrsUnits, minTens, minUnits, secTens, secUnits;
   logic          hrsBad, minBad, secBad;
   logic [3:0]    digitVal;
   logic          digitBad;

   bin2bcd6 u_hrs (.value(hrs_q), .limit(HOURS_MAX),  .tens(hrsTens), .units(hrsUnits), .invalid(hrsBad));
   bin2bcd6 u_min (.value(min_q), .limit(MINSEC_MAX), .tens(minTens), .units(minUnits), .invalid(minBad));
   bin2bcd6 u_sec (.value(sec_q), .limit(MINSEC_MAX), .tens(secTens), .units(secUnits), .invalid(secBad));

   // Outputs are built from the current index so they trail it by one clock;
   // the first cycle after reset only captures the snapshot and stays blank.
   always_comb begin
      step    = (presc_q == LAST);
      presc_d = step ? '0 : presc_q + PW'(1);
      idx_d   = idx_q;
      if (step) begin
         idx_d = (idx_q == DIG_HRS_T) ? DIG_SEC_U : digit_e'(idx_q + 3'd1);
      end
      take    = first_q || (step && (idx_q == DIG_HRS_T));
      frame_d = take;

      digitVal = 4'd0;
      digitBad = 1'b0;
      case (idx_q)
         DIG_SEC_U: begin digitVal = secUnits; digitBad = secBad; end
         DIG_SEC_T: begin digitVal = secTens;  digitBad = secBad; end
         DIG_MIN_U: begin digitVal = minUnits; digitBad = minBad; end
         DIG_MIN_T: begin digitVal = minTens;  digitBad = minBad; end
         DIG_HRS_U: begin digitVal = hrsUnits; digitBad = hrsBad; end
         DIG_HRS_T: begin digitVal = hrsTens;  digitBad = hrsBad; end
         default:   begin digitVal = 4'd0;     digitBad = 1'b1;   end
      endcase

      seg_d = digitBad ? SEG_DASH : seg_of(digitVal);
`ifdef LEADING_ZERO_BLANK_EN
      if ((idx_q == DIG_HRS_T) && !hrsBad && (hrsTens == 4'd0)) begin
         seg_d = SEG_BLANK;
      end
`endif
      an_d = ~(6'b000001 << idx_q);
      dp_d = !((idx_q == DIG_MIN_U) || (idx_q == DIG_HRS_U));

      if (first_q) begin
         an_d  = '1;
         seg_d = SEG_BLANK;
         dp_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
         idx_q   <= DIG_SEC_U;
         first_q <= 1'b1;
         hrs_q   <= '0;
         min_q   <= '0;
         sec_q   <= '0;
         an_q    <= '1;
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b1;
         frame_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         first_q <= 1'b0;
         if (take) begin
            hrs_q <= hours;
            min_q <= min;
            sec_q <= sec;
         end
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         frame_q <= frame_d;
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = dp_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Self-checking bench for time_display_scan at SCAN_DIV=4, using a cycle-count
// reference model of the scan and snapshot timing.
module tb_time_display_scan;

   localparam int DIV = 4;
   localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit BLANK_LEAD = 1'b1;
`else
   localparam bit BLANK_LEAD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] hoursIn = '0, minIn = '0, secIn = '0;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp, frame;

   int nChecks = 0;
   int nFails  = 0;

   // Model state: k counts rising edges since reset release.
   int k = 0;
   int mH = 0, mM = 0, mS = 0;
   int dH = 0, dM = 0, dS = 0;
   logic [5:0] expAn;
   logic [6:0] expSeg;
   logic       expDp, expFrame;

   time_display_scan #(.SCAN_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .hours(hoursIn), .min(minIn), .sec(secIn),
      .an(an), .seg(seg), .dp(dp), .frame(frame)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] expDigitSeg(int v, int vmax, bit tensSel, bit hrTens);
      int dgt;
      if (v > vmax) return 7'h3F;
      dgt = tensSel ? v / 10 : v % 10;
      if (BLANK_LEAD && hrTens && dgt == 0) return 7'h7F;
      return SEG_TAB[dgt];
   endfunction

   // One clock; frames fall on edge 1 and every 6*DIV edges, digits change every DIV edges
   // and the displayed digit lags the scan position by one clock.
   task automatic advance();
      int d;
      @(posedge clk);
      k++;
      dH = mH; dM = mM; dS = mS;
      expFrame = (k == 1) || (k % (6 * DIV) == 0);
      if (expFrame) begin
         mH = int'(hoursIn); mM = int'(minIn); mS = int'(secIn);
      end
      if (k == 1) begin
         expAn = 6'h3F; expSeg = 7'h7F; expDp = 1'b1;
      end else begin
         d = ((k - 1) / DIV) % 6;
         expAn = ~(6'd1 << d);
         expDp = !(d == 2 || d == 4);
         case (d)
            0: expSeg = expDigitSeg(dS, 59, 1'b0, 1'b0);
            1: expSeg = expDigitSeg(dS, 59, 1'b1, 1'b0);
            2: expSeg = expDigitSeg(dM, 59, 1'b0, 1'b0);
            3: expSeg = expDigitSeg(dM, 59, 1'b1, 1'b0);
            4: expSeg = expDigitSeg(dH, 23, 1'b0, 1'b0);
            default: expSeg = expDigitSeg(dH, 23, 1'b1, 1'b1);
         endcase
      end
      #1;
   endtask

   task automatic releaseReset();
      @(negedge clk);
      reset = 1'b1;
      k = 0; mH = 0; mM = 0; mS = 0;
   endtask

   task automatic test_reset();
      hoursIn = 6'd12; minIn = 6'd34; secIn = 6'd56;
      #2 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         nChecks++;
         if ({frame, dp, an, seg} !== {1'b0, 1'b1, 6'h3F, 7'h7F}) begin
            nFails++;
            $display("[TB] FAIL reset_state got=%b expected=%b", {frame, dp, an, seg}, {1'b0, 1'b1, 6'h3F, 7'h7F});
         end
      end
      releaseReset();
   endtask

   task automatic test_scan_pattern();
      for (int i = 0; i < 2 * 6 * DIV + 2; i++) begin
         advance();
         nChecks++;
         if ({frame, dp, an, seg} !== {expFrame, expDp, expAn, expSeg}) begin
            nFails++;
            $display("[TB] FAIL scan_pattern k=%0d got=%b expected=%b", k, {frame, dp, an, seg}, {expFrame, expDp, expAn, expSeg});
         end
      end
   endtask

   task automatic test_hold_between_frames();
      int guard = 0;
      while (expAn !== 6'b110111 && guard < 40) begin
         advance(); guard++;
      end
      nChecks++;
      if (expAn !== 6'b110111 || an !== 6'b110111) begin
         nFails++;
         $display("[TB] FAIL hold_reach_digit3 got=%b expected=%b", an, 6'b110111);
      end
      secIn = 6'd57;
      for (int i = 0; i < 2 * 6 * DIV; i++) begin
         advance();
         nChecks++;
         if ({frame, dp, an, seg} !== {expFrame, expDp, expAn, expSeg}) begin
            nFails++;
            $display("[TB] FAIL hold_snapshot k=%0d got=%b expected=%b", k, {frame, dp, an, seg}, {expFrame, expDp, expAn, expSeg});
         end
      end
   endtask

   task automatic test_no_tearing();
      hoursIn = 6'd0; minIn = 6'd59; secIn = 6'd59;
      for (int i = 0; i < 4 * 6 * DIV; i++) begin
         advance();
         if (i == 6 * DIV + 9) begin
            hoursIn = 6'd1; minIn = 6'd0; secIn = 6'd0;
         end
         nChecks++;
         if ({frame, dp, an, seg} !== {expFrame, expDp, expAn, expSeg}) begin
            nFails++;
            $display("[TB] FAIL no_tearing k=%0d got=%b expected=%b", k, {frame, dp, an, seg}, {expFrame, expDp, expAn, expSeg});
         end
      end
   endtask

   task automatic test_invalid_field();
      hoursIn = 6'd5; minIn = 6'd60; secIn = 6'd8;
      for (int i = 0; i < 3 * 6 * DIV; i++) begin
         advance();
         nChecks++;
         if ({frame, dp, an, seg} !== {expFrame, expDp, expAn, expSeg}) begin
            nFails++;
            $display("[TB] FAIL invalid_field k=%0d got=%b expected=%b", k, {frame, dp, an, seg}, {expFrame, expDp, expAn, expSeg});
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         advance();
         if ($urandom_range(0, 5) == 0) begin
            hoursIn = 6'($urandom_range(0, 31));
            minIn   = 6'($urandom_range(0, 63));
            secIn   = 6'($urandom_range(0, 63));
         end
         nChecks++;
         if ({frame, dp, an, seg} !== {expFrame, expDp, expAn, expSeg}) begin
            nFails++;
            $display("[TB] FAIL random k=%0d got=%b expected=%b", k, {frame, dp, an, seg}, {expFrame, expDp, expAn, expSeg});
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      int guard = 0;
      hoursIn = 6'd21; minIn = 6'd43; secIn = 6'd9;
      while (expAn !== 6'b101111 && guard < 40) begin
         advance(); guard++;
      end
      #2 reset = 1'b0;
      #1;
      nChecks++;
      if ({frame, dp, an, seg} !== {1'b0, 1'b1, 6'h3F, 7'h7F}) begin
         nFails++;
         $display("[TB] FAIL async_blank got=%b expected=%b", {frame, dp, an, seg}, {1'b0, 1'b1, 6'h3F, 7'h7F});
      end
      @(posedge clk);
      releaseReset();
      for (int i = 0; i < 2 * 6 * DIV; i++) begin
         advance();
         nChecks++;
         if ({frame, dp, an, seg} !== {expFrame, expDp, expAn, expSeg}) begin
            nFails++;
            $display("[TB] FAIL restart k=%0d got=%b expected=%b", k, {frame, dp, an, seg}, {expFrame, expDp, expAn, expSeg});
         end
         if (k == 2) begin
            nChecks++;
            if (an !== 6'b111110) begin
               nFails++;
               $display("[TB] FAIL restart_first_digit got=%b expected=%b", an, 6'b111110);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan_pattern();
      test_hold_between_frames();
      test_no_tearing();
      test_invalid_field();
      test_random();
      test_reset_mid_scan();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/time_display_scan.md
TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, giving the clk cycles each digit is lit; legal range 2..2^20.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  reset; one clock, reset asynchronous and active-low (reset=0 resets).
REQ-004 SHALL have port hours  in  6  binary hours from the time counter, legal 0..23.
REQ-005 SHALL have port min  in  6  binary minutes, legal 0..59.
REQ-006 SHALL have port sec  in  6  binary seconds, legal 0..59.
REQ-007 SHALL have port an  out  6  digit enables, active-low, one-hot-low when lit; bit0 = rightmost digit.
REQ-008 SHALL have port seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port dp  out  1  decimal point, active-low.
REQ-010 SHALL have port frame  out  1  one-cycle pulse when a new snapshot is taken.

Function
REQ-011 SHALL run a prescaler 0..SCAN_DIV-1; at SCAN_DIV-1 it SHALL wrap to 0 and emit an internal step.
REQ-012 SHALL hold a digit index 0..5 that advances by 1 on each step and wraps 5->0.
REQ-013 Digit map SHALL be: 0 sec units, 1 sec tens, 2 min units, 3 min tens, 4 hours units, 5 hours tens.
REQ-014 SHALL snapshot hours/min/sec into internal registers on the step that wraps index 5->0, and on the first clk edge after reset release; frame SHALL pulse high in that same cycle.
REQ-015 Displayed digits SHALL come only from the snapshot, never directly from the inputs, so a frame is never torn by a mid-scan carry (e.g. 00:59:59 -> 01:00:00).
REQ-016 Each snapshot field SHALL be split to tens/units (tens = v/10, units = v%10), using only 6-bit arithmetic.
REQ-017 A field above its legal maximum (hours>23, min>59, sec>59) SHALL display as dash,dash (only segment g lit) in both of its digits.
REQ-018 an, seg and dp SHALL be registered and SHALL reflect the new index exactly one clk after the index changes.
REQ-019 dp SHALL be 0 (lit) on digits 2 and 4, as hh.mm.ss separators, and 1 on all other digits.
REQ-020 Segment codes SHALL be the standard 0-9 patterns; for example, 0 = 7'b1000000 and 8 = 7'b0000000.
REQ-021 Input changes between snapshots SHALL have no effect on the outputs until the next frame.

Reset
REQ-022 While reset=0, SHALL force: an=6'b111111, seg=7'b1111111, dp=1, frame=0, prescaler=0, index=0, and snapshot=0.
REQ-023 If reset asserts mid-scan, outputs SHALL blank asynchronously; after release, scanning SHALL restart at digit 0 with a fresh snapshot (REQ-014).

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN: when defined, the hours-tens digit SHALL be blank (seg=7'b1111111, an still driven) whenever its value is 0; when undefined, it SHALL show '0'. No other behaviour changes.

Structure
REQ-025 Package time_disp_pkg SHALL hold the segment constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK), NUM_DIGITS=6, and the legal maxima 23/59.
REQ-026 SHALL instantiate one combinational sub-module bin2bcd6 (6-bit in; tens, units and invalid-flag out, limit as input), with one instance per snapshot field.

Verification (SCAN_DIV=4)
REQ-027 Release reset with inputs 12:34:56 -> frame pulses on the first edge; then an sequence 111110..011111 at 4-cycle pitch, with seg = 6,5,4,3,2,1, and dp=0 only on an=111011 and an=101111.
REQ-028 Change sec from 56 to 57 while digit 3 is lit -> digit 0 keeps showing 6 until the next frame pulse, then shows 7.
REQ-029 Inputs 00:59:59 changing to 01:00:00 mid-scan -> every frame shows exactly one of the two times in full; never a mix.
REQ-030 Apply min=60 -> digits 2 and 3 show seg=7'b0111111; the other digits are normal.
REQ-031 Assert reset while digit 4 is lit -> an=111111 in the same cycle; after release, digit 0 is lit first.
REQ-032 Apply hours=5, with and without LEADING_ZERO_BLANK_EN -> digit 5 shows blank or 7'b1000000 respectively.
